btn_debounce_repeat: RTL
========================

// Module: btn_debounce_repeat
// PURPOSE
// Per-digit button conditioner upstream of the digit counters. Takes the active-high
// raw button lines (already inverted at top level), synchronises and debounces them,
// and emits a one-clk increment pulse per accepted press, plus optional auto-repeat
// while held. Pulses drive the counters' inc inputs directly.
// PARAMETERS
// CHANNELS    3      number of independent button channels (one per digit)
// TICK_DIV    1000   clk cycles per debounce tick (1 ms at 1 MHz); 2..65535
// DEB_TICKS   20     ticks a level must be stable to be accepted; 1..65535
// HOLD_TICKS  500    ticks held before the first auto-repeat pulse; 1..65535
// REP_TICKS   100    ticks between subsequent repeat pulses; 1..65535
// PORTS
// clk        in   1         system clock
// rst_n      in   1         asynchronous active-low reset
// btn_in     in   CHANNELS  raw buttons, active high, asynchronous to clk
// rep_en     in   1         1 = auto-repeat enabled (synchronous to clk)
// btn_pulse  out  CHANNELS  one-clk pulse per accepted press / repeat
// btn_level  out  CHANNELS  debounced button state
// BEHAVIOUR
// - Reset (rst_n=0, async): btn_pulse=0, btn_level=0, sync flops=0, prescaler=0,
//   every channel FSM=IDLE, every tick counter=0. All outputs are registered.
// - Sync: 2-flop synchroniser per channel; s[i] = btn_in[i] after 2 clk.
// - Prescaler: shared 16-bit counter 0..TICK_DIV-1, wraps; tick=1 in the cycle it
//   equals TICK_DIV-1. All channels see the same tick.
// - Per channel: 16-bit tick counter tc, cleared on every state change.
//   tc advances only on tick and saturates at 65535.
// - FSM states and transitions (evaluated each clk):
//   IDLE:     s=1 -> DEB_PRESS.
//   DEB_PRESS: s=0 -> IDLE (no pulse). On tick with tc==DEB_TICKS-1 and s=1 ->
//             HELD; btn_level<=1; btn_pulse<=1 for exactly one clk.
//   HELD:     s=0 -> DEB_REL. On tick with tc==HOLD_TICKS-1 and rep_en=1 ->
//             REPEAT; btn_pulse<=1. rep_en=0: tc saturates, no pulse.
//   REPEAT:   s=0 -> DEB_REL. On tick with tc==REP_TICKS-1 and rep_en=1: pulse,
//             tc<=0 (stay). rep_en=0: no pulses, tc holds at REP_TICKS-1.
//   DEB_REL:  s=1 -> HELD (tc=0, no pulse, level stays 1). On tick with
//             tc==DEB_TICKS-1 and s=0 -> IDLE; btn_level<=0. Release never pulses.
// - s change and tick in the same clk: the s transition wins (count restarts).
// - Press latency (btn_in rise to btn_pulse): 2 sync + 1 + between (DEB_TICKS-1)
//   and DEB_TICKS tick periods, depending on prescaler phase.
// - Channels are fully independent; simultaneous presses pulse in the same clk.
// - btn_pulse is never high on two consecutive clk cycles.
// - Reset mid-press: outputs drop immediately; after release of reset a still-held
//   button is re-debounced from IDLE and produces a fresh pulse.
// TESTING (TICK_DIV=4, DEB_TICKS=3, HOLD_TICKS=5, REP_TICKS=2, CHANNELS=3)
// 1. btn_in[0]=1 held 40 clk, rep_en=0 -> exactly one btn_pulse[0], 11..15 clk after
//    rise; btn_level[0]=1 same clk; release -> level 0 after 11..15 clk, no pulse.
// 2. btn_in[1] toggles every 3 clk for 30 clk, then 0 -> zero pulses, btn_level[1]=0.
// 3. rep_en=1, btn_in[2] held 100 clk -> first pulse, second 20 clk later, then one
//    every 8 clk until release; no pulse after release.
// 4. btn_in[0] and btn_in[2] rise same clk, same prescaler phase -> pulses in the same
//    clk; btn_pulse[1] stays 0.
// 5. In HELD, btn_in[0] low for 2 clk (< 1 tick) -> no extra pulse, level stays 1.
// 6. rst_n pulsed low while HELD -> pulse/level 0 asynchronously; button still high
//    -> new pulse 11..15 clk after rst_n release.

Source files
------------

// File: rtl/btn_debounce_repeat_if.sv
// Button conditioner bus: raw buttons and repeat enable in, debounced pulses and levels out.
interface btn_debounce_repeat_if #(
   parameter int unsigned CHANNELS = 3
);
   logic [CHANNELS-1:0] btn_in;
   logic                rep_en;
   logic [CHANNELS-1:0] btn_pulse;
   logic [CHANNELS-1:0] btn_level;

   modport master (
      output btn_in,
      output rep_en,
      input  btn_pulse,
      input  btn_level
   );

   modport slave (
      input  btn_in,
      input  rep_en,
      output btn_pulse,
      output btn_level
   );
endinterface

// File: rtl/btn_debounce_repeat.sv
// Per-channel button synchroniser, debouncer and auto-repeat pulse generator.
// A shared prescaler produces the debounce tick; each channel runs its own FSM
// and tick counter. Pulses and levels leave through registers.
module btn_debounce_repeat #(
   parameter int unsigned CHANNELS   = 3,
   parameter int unsigned TICK_DIV   = 1000,
   parameter int unsigned DEB_TICKS  = 20,
   parameter int unsigned HOLD_TICKS = 500,
   parameter int unsigned REP_TICKS  = 100
) (
   input logic                  clk,
   input logic                  rst_n,
   btn_debounce_repeat_if.slave bus
);

   localparam int unsigned CW = 16;
   localparam logic [CW-1:0] TC_MAX    = '1;
   localparam logic [CW-1:0] DIV_LAST  = CW'(TICK_DIV - 1);
   localparam logic [CW-1:0] DEB_LAST  = CW'(DEB_TICKS - 1);
   localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_TICKS - 1);
   localparam logic [CW-1:0] REP_LAST  = CW'(REP_TICKS - 1);

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      DEB_PRESS = 3'd1,
      HELD      = 3'd2,
      REPEAT    = 3'd3,
      DEB_REL   = 3'd4
   } state_t;

   logic [CHANNELS-1:0] sync1;
   logic [CHANNELS-1:0] sync2;
   logic [CW-1:0]       pre;
   logic                tick;
   logic [CHANNELS-1:0] pulse_d;
   logic [CHANNELS-1:0] level_d;

   // Two-flop synchroniser for the asynchronous button lines
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1 <= '0;
         sync2 <= '0;
      end else begin
         sync1 <= bus.btn_in;
         sync2 <= sync1;
      end
   end

   // Shared prescaler; tick marks the last count of each period
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pre <= '0;
      end else if (pre == DIV_LAST) begin
         pre <= '0;
      end else begin
         pre <= pre + CW'(1);
      end
   end

   assign tick = (pre == DIV_LAST);

   for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
      state_t        state;
      state_t        state_nxt;
      logic [CW-1:0] tc;
      logic [CW-1:0] tc_nxt;
      logic          pulse_nxt;
      logic          level_nxt;
      logic          s;

      assign s = sync2[i];

      // State and tick counter registers
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            state <= IDLE;
            tc    <= '0;
         end else begin
            state <= state_nxt;
            tc    <= tc_nxt;
         end
      end

      // Next state: a change of s always wins over a coincident tick
      always_comb begin
         state_nxt = state;
         unique case (state)
            IDLE: begin
               if (s) state_nxt = DEB_PRESS;
            end
            DEB_PRESS: begin
               if (!s)                          state_nxt = IDLE;
               else if (tick && tc == DEB_LAST) state_nxt = HELD;
            end
            HELD: begin
               if (!s)                                         state_nxt = DEB_REL;
               else if (tick && tc == HOLD_LAST && bus.rep_en) state_nxt = REPEAT;
            end
            REPEAT: begin
               if (!s) state_nxt = DEB_REL;
            end
            DEB_REL: begin
               if (s)                           state_nxt = HELD;
               else if (tick && tc == DEB_LAST) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
         endcase
      end

      // Counter update and next values of the registered outputs
      always_comb begin
         tc_nxt    = tc;
         pulse_nxt = 1'b0;
         level_nxt = (state_nxt == HELD) || (state_nxt == REPEAT) || (state_nxt == DEB_REL);
         if (state_nxt != state) begin
            tc_nxt    = '0;
            pulse_nxt = (state == DEB_PRESS && state_nxt == HELD) ||
                        (state == HELD && state_nxt == REPEAT);
         end else if (tick) begin
            if (state == REPEAT) begin
               // Repeat counter parks at its terminal value while repeat is disabled
               if (tc == REP_LAST) begin
                  if (bus.rep_en) begin
                     tc_nxt    = '0;
                     pulse_nxt = 1'b1;
                  end
               end else begin
                  tc_nxt = tc + CW'(1);
               end
            end else if (tc != TC_MAX) begin
               tc_nxt = tc + CW'(1);
            end
         end
      end

      assign pulse_d[i] = pulse_nxt;
      assign level_d[i] = level_nxt;
   end

   // Registered outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bus.btn_pulse <= '0;
         bus.btn_level <= '0;
      end else begin
         bus.btn_pulse <= pulse_d;
         bus.btn_level <= level_d;
      end
   end

endmodule
